// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings for the Hi/Lo multiply/divide controller.
package hilo_muldiv_pkg;

  localparam int unsigned ITER_COUNT = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MADD  = 3'b100,
    OP_MSUB  = 3'b101,
    OP_MTHI  = 3'b110,
    OP_MTLO  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_signed_op(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic is_div_op(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_move_op(input op_e op);
    return (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

endpackage

// File: rtl/iterative_muldiv_datapath.sv
// Radix-2 shift-add multiplier / restoring divider sharing one 64-bit register.
// Multiply: acc = {partial, multiplier}; divide: acc = {remainder, quotient}.
module iterative_muldiv_datapath
  import hilo_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] load_val,
  input  logic [31:0] operand_b,
  output logic [63:0] acc
);

  logic [63:0] acc_q, acc_d;
  logic [31:0] addend;
  logic [32:0] add_sum;
  logic [32:0] trial;
  logic [32:0] sub_diff;

  always_comb begin
    acc_d    = acc_q;
    addend   = acc_q[0] ? operand_b : '0;
    add_sum  = {1'b0, acc_q[63:32]} + {1'b0, addend};
    trial    = {acc_q[63:32], acc_q[31]};
    sub_diff = trial - {1'b0, operand_b};
    if (load) begin
      acc_d = {32'd0, load_val};
    end else if (step) begin
      if (is_div) begin
        if (!sub_diff[32]) acc_d = {sub_diff[31:0], acc_q[30:0], 1'b1};
        else               acc_d = {trial[31:0],    acc_q[30:0], 1'b0};
      end else begin
        acc_d = {add_sum, acc_q[31:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/hilo_muldiv_controller.sv
// Hi/Lo multiply/divide controller: FSM, operand latch, sign fix and accumulate.
module hilo_muldiv_controller
  import hilo_muldiv_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] HiIn,
  input  logic [31:0] LoIn,
  input  logic        ReadReq,
  output logic        Busy,
  output logic        Stall,
  output logic        HiLoWrite,
  output logic [31:0] WriteHiData,
  output logic [31:0] WriteLoData,
  output logic        DivByZero
);

  state_e      state_q, state_d;
  op_e         op_q, op_d, op_in;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        dbz_q, dbz_d;
  logic [31:0] wr_hi_q, wr_hi_d, wr_lo_q, wr_lo_d;

  logic        dp_load, dp_step;
  logic [31:0] mag_a_in, mag_b;
  logic [63:0] dp_acc;
  logic        neg_res;
  logic [63:0] prod_s;
  logic [31:0] quo_raw, rem_raw, quo_s, rem_s;
  logic [63:0] result;

  assign op_in    = op_e'(Op);
  assign mag_a_in = (is_signed_op(op_in) && A[31]) ? -A : A;
  // Divisor/multiplicand magnitude comes from the latched B, stable during CALC.
  assign mag_b    = (is_signed_op(op_q) && b_q[31]) ? -b_q : b_q;

  iterative_muldiv_datapath u_dp (
    .clk       (Clk),
    .rst       (Rst),
    .load      (dp_load),
    .step      (dp_step),
    .is_div    (is_div_op(op_q)),
    .load_val  (mag_a_in),
    .operand_b (mag_b),
    .acc       (dp_acc)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    dp_load = 1'b0;
    dp_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          op_d  = op_in;
          a_d   = A;
          b_d   = B;
          hi_d  = HiIn;
          lo_d  = LoIn;
          cnt_d = '0;
          dbz_d = is_div_op(op_in) && (B == '0);
          if (is_move_op(op_in) || dbz_d) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
            dp_load = 1'b1;
          end
        end
      end
      ST_CALC: begin
        dp_step = 1'b1;
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == 6'(ITER_COUNT - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    neg_res = a_q[31] ^ b_q[31];
    prod_s  = neg_res ? -dp_acc : dp_acc;
    quo_raw = dp_acc[31:0];
    rem_raw = dp_acc[63:32];
    quo_s   = neg_res ? -quo_raw : quo_raw;
    rem_s   = a_q[31] ? -rem_raw : rem_raw;
    case (op_q)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = dp_acc;
      OP_DIV:   result = {rem_s, quo_s};
      OP_DIVU:  result = dp_acc;
      OP_MADD:  result = {hi_q, lo_q} + prod_s;
      OP_MSUB:  result = {hi_q, lo_q} - prod_s;
      OP_MTHI:  result = {a_q, lo_q};
      OP_MTLO:  result = {hi_q, a_q};
      default:  result = {hi_q, lo_q};
    endcase
    if (dbz_q) result = {wr_hi_q, wr_lo_q};
    wr_hi_d = (state_q == ST_DONE) ? result[63:32] : wr_hi_q;
    wr_lo_d = (state_q == ST_DONE) ? result[31:0]  : wr_lo_q;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
      wr_hi_q <= '0;
      wr_lo_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
      wr_hi_q <= wr_hi_d;
      wr_lo_q <= wr_lo_d;
    end
  end

  assign Busy        = (state_q != ST_IDLE);
  assign Stall       = Busy & (ReadReq | Start);
  assign HiLoWrite   = (state_q == ST_DONE) & ~dbz_q;
  assign DivByZero   = (state_q == ST_DONE) &  dbz_q;
  // In DONE the fresh result is presented combinationally; the flops hold it afterwards.
  assign WriteHiData = wr_hi_d;
  assign WriteLoData = wr_lo_d;

endmodule

// File: tb/tb_hilo_muldiv_controller.sv
module tb_hilo_muldiv_controller;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'd0;
  logic [31:0] A = '0, B = '0, HiIn = '0, LoIn = '0;
  logic        ReadReq = 1'b0;
  logic        Busy, Stall, HiLoWrite, DivByZero;
  logic [31:0] WriteHiData, WriteLoData;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [63:0] last_exp = '0;

  hilo_muldiv_controller dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Start       (Start),
    .Op          (Op),
    .A           (A),
    .B           (B),
    .HiIn        (HiIn),
    .LoIn        (LoIn),
    .ReadReq     (ReadReq),
    .Busy        (Busy),
    .Stall       (Stall),
    .HiLoWrite   (HiLoWrite),
    .WriteHiData (WriteHiData),
    .WriteLoData (WriteLoData),
    .DivByZero   (DivByZero)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic [63:0] exp;
    bit          dbz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned 64-bit arithmetic on the architectural rules.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, b, hi, lo,
                                output logic [63:0] res, output bit dbz);
    longint sa, sb, q, r;
    logic [63:0] ps, ua, ub;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ps  = 64'(sa * sb);
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    dbz = 1'b0;
    res = '0;
    case (op)
      3'd0: res = ps;
      3'd1: res = ua * ub;
      3'd2: if (b == 0) dbz = 1'b1;
            else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
      3'd3: if (b == 0) dbz = 1'b1;
            else res = {32'(ua % ub), 32'(ua / ub)};
      3'd4: res = {hi, lo} + ps;
      3'd5: res = {hi, lo} - ps;
      3'd6: res = {a, lo};
      default: res = {hi, a};
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, b, hi, lo,
                        input logic [63:0] exp, input bit exp_dbz, input string nm);
    int unsigned exp_lat, wr_cyc, z_cyc, n_wr, k;
    logic [63:0] wr_data;
    bit done;
    exp_lat = (op >= 3'd6 || exp_dbz) ? 1 : 33;
    wr_cyc = 0; z_cyc = 0; n_wr = 0; wr_data = '0; done = 0; k = 0;
    @(negedge Clk);
    Op = op; A = a; B = b; HiIn = hi; LoIn = lo; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    while (!done && k < 40) begin
      k++;
      @(negedge Clk);
      if (HiLoWrite) begin n_wr++; wr_cyc = k; wr_data = {WriteHiData, WriteLoData}; end
      if (DivByZero) z_cyc = k;
      if (!Busy) done = 1;
    end
    chk({nm, " busy_fall"}, 64'(done), 64'(1));
    if (exp_dbz) begin
      chk({nm, " dbz_cycle"}, 64'(z_cyc), 64'(1));
      chk({nm, " dbz_nowrite"}, 64'(n_wr), 64'(0));
      chk({nm, " dbz_busy_cycles"}, 64'(k), 64'(2));
    end else begin
      chk({nm, " write_count"}, 64'(n_wr), 64'(1));
      chk({nm, " latency"}, 64'(wr_cyc), 64'(exp_lat));
      chk({nm, " data"}, wr_data, exp);
      chk({nm, " nodbz"}, 64'(z_cyc), 64'(0));
      last_exp = exp;
    end
    chk({nm, " hold"}, {WriteHiData, WriteLoData}, last_exp);
  endtask

  initial begin
    logic [63:0] m_res;
    bit m_dbz;
    logic [2:0] rop;
    logic [31:0] ra, rb, rh, rl;
    bit wr_seen;

    vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'd5, 32'd0, 32'd0, 64'hFFFFFFFF_FFFFFFF1, 1'b0};
    vecs[1]  = '{3'd2, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 64'hFFFFFFFF_FFFFFFFD, 1'b0};
    vecs[2]  = '{3'd3, 32'd7, 32'd2, 32'd0, 32'd0, 64'h00000001_00000003, 1'b0};
    vecs[3]  = '{3'd4, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 64'h00000001_00000000, 1'b0};
    vecs[4]  = '{3'd5, 32'd1, 32'd1, 32'd0, 32'd0, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
    vecs[5]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 64'hFFFFFFFE_00000001, 1'b0};
    vecs[6]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 64'h00000000_80000000, 1'b0};
    vecs[7]  = '{3'd6, 32'hDEADBEEF, 32'd9, 32'd1, 32'd2, 64'hDEADBEEF_00000002, 1'b0};
    vecs[8]  = '{3'd7, 32'h00001234, 32'd9, 32'd5, 32'd6, 64'h00000005_00001234, 1'b0};
    vecs[9]  = '{3'd3, 32'd77, 32'd0, 32'd3, 32'd4, 64'd0, 1'b1};
    vecs[10] = '{3'd2, 32'd7, 32'hFFFFFFFE, 32'd0, 32'd0, 64'h00000001_FFFFFFFD, 1'b0};
    vecs[11] = '{3'd0, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 64'h40000000_00000000, 1'b0};

    // Reset state
    #1;
    chk("reset_outputs", {59'd0, Busy, Stall, HiLoWrite, DivByZero, 1'b0},  64'd0);
    chk("reset_data", {WriteHiData, WriteLoData}, 64'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk) Rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
             vecs[i].exp, vecs[i].dbz, $sformatf("vec%0d", i));

    // Randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom; rb = $urandom; rh = $urandom; rl = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 100));
      model(rop, ra, rb, rh, rl, m_res, m_dbz);
      run_op(rop, ra, rb, rh, rl, m_res, m_dbz, $sformatf("rand%0d", i));
    end

    // Stall while busy, second Start ignored, then MTLO right after
    model(3'd0, 32'hFFFFFFFD, 32'd5, 32'd0, 32'd0, m_res, m_dbz);
    @(negedge Clk);
    Op = 3'd0; A = 32'hFFFFFFFD; B = 32'd5; HiIn = '0; LoIn = '0; Start = 1'b1;
    @(posedge Clk);
    #1;
    for (int k = 1; k <= 35; k++) begin
      Start   = (k >= 10 && k <= 34);
      ReadReq = (k >= 10 && k <= 33);
      if (k == 34) begin Op = 3'd7; A = 32'h1234; HiIn = 32'h55; LoIn = 32'h66; end
      else if (k >= 10) begin Op = 3'd6; A = 32'hAAAA5555; end
      @(negedge Clk);
      chk($sformatf("stall_c%0d", k), 64'(Stall), 64'(k >= 10 && k <= 33));
      chk($sformatf("busy_c%0d", k), 64'(Busy), 64'(k <= 33 || k == 35));
      chk($sformatf("write_c%0d", k), 64'(HiLoWrite), 64'(k == 33 || k == 35));
      if (k == 33) chk("stall_mult_data", {WriteHiData, WriteLoData}, m_res);
      if (k == 35) chk("stall_mtlo_data", {WriteHiData, WriteLoData}, 64'h00000055_00001234);
      @(posedge Clk);
      #1;
    end
    Start = 1'b0; ReadReq = 1'b0;
    last_exp = 64'h00000055_00001234;

    // Reset in the middle of a DIV
    @(negedge Clk);
    Op = 3'd2; A = 32'hFFFFFFF9; B = 32'd2; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    ReadReq = 1'b1;
    wr_seen = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge Clk);
      if (HiLoWrite) wr_seen = 1;
    end
    @(posedge Clk);
    #1 Rst = 1'b1;
    #1;
    chk("midrst_flags", {60'd0, Busy, Stall, HiLoWrite, DivByZero}, 64'd0);
    chk("midrst_data", {WriteHiData, WriteLoData}, 64'd0);
    @(negedge Clk);
    Rst = 1'b0; ReadReq = 1'b0;
    last_exp = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (HiLoWrite) wr_seen = 1;
    end
    chk("midrst_nowrite", 64'(wr_seen), 64'd0);
    run_op(3'd3, 32'd7, 32'd2, 32'd0, 32'd0, 64'h00000001_00000003, 1'b0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_controller.md
HILO_MULDIV_CONTROLLER -- requirements
Module: hilo_muldiv_controller

Interface
REQ-001 SHALL have port Clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port Rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port Start, input, 1 bit: request to issue one Hi/Lo operation.
REQ-004 SHALL have port Op, input, 3 bits: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB, 110 MTHI, 111 MTLO.
REQ-005 SHALL have ports A and B, input, 32 bits each: rs and rt operands.
REQ-006 SHALL have ports HiIn and LoIn, input, 32 bits each: current Hi/Lo register values.
REQ-007 SHALL have port ReadReq, input, 1 bit: an MFHI/MFLO is waiting in decode.
REQ-008 SHALL have port Busy, output, 1 bit: the controller is not IDLE.
REQ-009 SHALL have port Stall, output, 1 bit: freeze the front of the pipeline.
REQ-010 SHALL have port HiLoWrite, output, 1 bit: one-cycle write strobe to the Hi/Lo register file.
REQ-011 SHALL have ports WriteHiData and WriteLoData, output, 32 bits each: write values.
REQ-012 SHALL have port DivByZero, output, 1 bit: one-cycle flag.

Function
REQ-013 SHALL implement states IDLE, CALC and DONE.
REQ-014 IDLE, Start=1: SHALL latch Op, A, B, HiIn and LoIn, clear the 6-bit iteration counter, and go to CALC; MTHI/MTLO and divide-by-zero SHALL go directly to DONE.
REQ-015 CALC SHALL perform one radix-2 step per cycle (shift-add multiply, restoring divide) for exactly 32 cycles, then go to DONE.
REQ-016 DONE SHALL last one cycle, assert HiLoWrite with final data, then go to IDLE; HiLoWrite is 0 in all other states.
REQ-017 Latency: Start sampled at edge 0 SHALL give HiLoWrite high during cycle 33 for MULT/MULTU/DIV/DIVU/MADD/MSUB and during cycle 1 for MTHI/MTLO.
REQ-018 MULT/DIV SHALL operate on magnitudes and then correct signs; the quotient is negative iff operand signs differ; the remainder takes the sign of the dividend (A).
REQ-019 MULTU/DIVU SHALL treat operands as unsigned; the product is {Hi,Lo}; DIV/DIVU SHALL give Lo=quotient, Hi=remainder.
REQ-020 MADD/MSUB SHALL take the signed 64-bit product and produce {HiIn,LoIn} + product or {HiIn,LoIn} - product, modulo 2^64, using the latched HiIn/LoIn.
REQ-021 MTHI SHALL write Hi=A, Lo=LoIn; MTLO SHALL write Hi=HiIn, Lo=A.
REQ-022 DIV/DIVU with B=0: SHALL pulse DivByZero in DONE with HiLoWrite=0, leaving Hi/Lo unchanged.
REQ-023 Start while Busy SHALL be ignored (not queued).
REQ-024 SHALL drive Stall = Busy & (ReadReq | Start); the issuer holds Start until Busy falls.
REQ-025 In DONE: ReadReq SHALL still stall; Start SHALL be accepted only on the following IDLE cycle.
REQ-026 SHALL hold WriteHiData/WriteLoData at their last values outside DONE.

Reset
REQ-027 Rst=1 SHALL force IDLE, counter 0 and all latched operands 0, and drive Busy=0, Stall=0, HiLoWrite=0, DivByZero=0, WriteHiData=0, WriteLoData=0.
REQ-028 Rst asserted mid-operation SHALL abort the operation without any HiLoWrite.

Structure
REQ-029 A shared package SHALL hold the Op encodings, the state encoding, and the constant ITER_COUNT=32.
REQ-030 The shift/add/subtract registers SHALL be one sub-module, iterative_muldiv_datapath; the FSM, sign fix and accumulate SHALL stay in the top module.

Verification
REQ-031 MULT A=0xFFFFFFFD (-3), B=5 -> HiLoWrite in cycle 33, Hi=0xFFFFFFFF, Lo=0xFFFFFFF1; Busy high in cycles 1-33.
REQ-032 DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIVU A=7, B=2 -> Lo=3, Hi=1.
REQ-033 MADD HiIn=0, LoIn=0xFFFFFFFF, A=1, B=1 -> Hi=1, Lo=0; MSUB HiIn=0, LoIn=0, A=1, B=1 -> Hi=Lo=0xFFFFFFFF.
REQ-034 DIVU B=0 -> DivByZero high in cycle 1, HiLoWrite never high, Busy low by cycle 2.
REQ-035 MULT issued, ReadReq=1 and a second Start at cycle 10 -> Stall=1 in cycles 10-33, second Start ignored; MTLO A=0x1234 at cycle 34 -> Lo=0x1234 in cycle 35.
REQ-036 Rst pulse at cycle 15 of a DIV -> all outputs 0 immediately, no HiLoWrite, next Start accepted normally.
